// File: rtl/bolme_pkg.sv
// Shared encodings and helpers for the parametrised integer divider.
// The two's-complement helper works at MAX_XLEN width; callers cast down to their XLEN.
package bolme_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    ISLEM_DIV  = 2'b00,
    ISLEM_DIVU = 2'b01,
    ISLEM_REM  = 2'b10,
    ISLEM_REMU = 2'b11
  } islem_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // Conditional negate: yields |x| for a negative x, and -|x| when a sign is restored.
  function automatic logic [MAX_XLEN-1:0] tumle(input logic [MAX_XLEN-1:0] deger,
                                                input logic                etkin);
    return etkin ? (~deger + MAX_XLEN'(1)) : deger;
  endfunction

  function automatic logic is_rem(input islem_e op);
    return (op == ISLEM_REM) || (op == ISLEM_REMU);
  endfunction

  function automatic logic is_signed_op(input islem_e op);
    return (op == ISLEM_DIV) || (op == ISLEM_REM);
  endfunction

endpackage

// File: rtl/bolme_adimi.sv
// One restoring shift-subtract step on {remainder, quotient}; purely combinational.
module bolme_adimi #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   i_kalan,
  input  logic [XLEN-1:0] i_bolum,
  input  logic [XLEN-1:0] i_bolen,
  output logic [XLEN:0]   o_kalan,
  output logic [XLEN-1:0] o_bolum
);

  logic [XLEN+1:0] w_kaydir;
  logic [XLEN+1:0] w_fark;
  logic            w_borc;

  // The remainder stays below the divisor, so its top bit is always 0 here and
  // the shifted value fits in XLEN+1 bits; bit XLEN+1 of the difference is the borrow.
  assign w_kaydir = {i_kalan, i_bolum[XLEN-1]};
  assign w_fark   = w_kaydir - {2'b00, i_bolen};
  assign w_borc   = w_fark[XLEN+1];

  assign o_kalan = w_borc ? w_kaydir[XLEN:0] : w_fark[XLEN:0];
  assign o_bolum = {i_bolum[XLEN-2:0], ~w_borc};

endmodule

// File: rtl/bolme_birimi_param.sv
// Multi-cycle RISC-V M divider (DIV/DIVU/REM/REMU), ADIM_BIT quotient bits per cycle.
// Divide-by-zero and signed overflow bypass the iteration and resolve in FIX.
module bolme_birimi_param
  import bolme_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADIM_BIT = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            basla_i,
  input  logic [1:0]      islem_i,
  input  logic [XLEN-1:0] bolunen_i,
  input  logic [XLEN-1:0] bolen_i,
  input  logic            iptal_i,
  output logic [XLEN-1:0] sonuc_o,
  output logic            bitti_o,
  output logic            mesgul_o
);

  localparam int N     = XLEN / ADIM_BIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] MIN_DEGER = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state;
  islem_e            r_islem;
  logic [XLEN:0]     r_kalan;
  logic [XLEN-1:0]   r_bolum;
  logic [XLEN-1:0]   r_bolen;
  logic [CNT_W-1:0]  r_sayac;
  logic              r_neg_bolum;
  logic              r_neg_kalan;
  logic              r_ozel;
  logic              r_sifir;
  logic [XLEN-1:0]   r_sonuc;
  logic              r_bitti;
  logic              r_mesgul;

  // Start-side operand decode.
  islem_e            w_islem;
  logic              w_isaretli;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_sifir;
  logic              w_tasma;
  logic [XLEN-1:0]   w_sonuc;

  assign w_islem    = islem_e'(islem_i);
  assign w_isaretli = is_signed_op(w_islem);
  assign w_a_neg    = w_isaretli & bolunen_i[XLEN-1];
  assign w_b_neg    = w_isaretli & bolen_i[XLEN-1];
  assign w_a_abs    = XLEN'(tumle(MAX_XLEN'(bolunen_i), w_a_neg));
  assign w_b_abs    = XLEN'(tumle(MAX_XLEN'(bolen_i), w_b_neg));
  assign w_sifir    = (bolen_i == '0);
  assign w_tasma    = w_isaretli && (bolunen_i == MIN_DEGER) && (&bolen_i);

  // Step chain: ADIM_BIT restoring steps resolved combinationally each CALC cycle.
  logic [XLEN:0]   w_kalan [ADIM_BIT+1];
  logic [XLEN-1:0] w_bolum [ADIM_BIT+1];

  assign w_kalan[0] = r_kalan;
  assign w_bolum[0] = r_bolum;

  for (genvar g = 0; g < ADIM_BIT; g++) begin : g_adim
    bolme_adimi #(.XLEN(XLEN)) u_adim (
      .i_kalan (w_kalan[g]),
      .i_bolum (w_bolum[g]),
      .i_bolen (r_bolen),
      .o_kalan (w_kalan[g+1]),
      .o_bolum (w_bolum[g+1])
    );
  end

  always_comb begin
    // NOTE: default first so every path assigns w_sonuc; a missing else would infer a latch.
    w_sonuc = '0;
    if (r_ozel) begin
      if (r_sifir) w_sonuc = is_rem(r_islem) ? r_bolum : '1;
      else         w_sonuc = is_rem(r_islem) ? '0 : MIN_DEGER;
    end else if (is_rem(r_islem)) begin
      w_sonuc = XLEN'(tumle(MAX_XLEN'(r_kalan[XLEN-1:0]), r_neg_kalan));
    end else begin
      w_sonuc = XLEN'(tumle(MAX_XLEN'(r_bolum), r_neg_bolum));
    end
  end

  // NOTE: state updates use <= so every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: all registers here are plain flops (no memory arrays), so each one is cleared.
      r_state     <= IDLE;
      r_islem     <= ISLEM_DIV;
      r_kalan     <= '0;
      r_bolum     <= '0;
      r_bolen     <= '0;
      r_sayac     <= '0;
      r_neg_bolum <= 1'b0;
      r_neg_kalan <= 1'b0;
      r_ozel      <= 1'b0;
      r_sifir     <= 1'b0;
      r_sonuc     <= '0;
      r_bitti     <= 1'b0;
      r_mesgul    <= 1'b0;
    end else begin
      r_bitti <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (basla_i) begin
            r_islem     <= w_islem;
            r_bolen     <= w_b_abs;
            r_kalan     <= '0;
            r_sayac     <= CNT_W'(N - 1);
            r_neg_bolum <= w_a_neg ^ w_b_neg;
            r_neg_kalan <= w_a_neg;
            r_mesgul    <= 1'b1;
            if (w_sifir || w_tasma) begin
              // The raw dividend is parked in the quotient register for the REM-by-zero result.
              r_state <= FIX;
              r_ozel  <= 1'b1;
              r_sifir <= w_sifir;
              r_bolum <= bolunen_i;
            end else begin
              r_state <= CALC;
              r_ozel  <= 1'b0;
              r_sifir <= 1'b0;
              r_bolum <= w_a_abs;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (iptal_i) begin
            r_state  <= IDLE;
            r_mesgul <= 1'b0;
          end else begin
            r_kalan <= w_kalan[ADIM_BIT];
            r_bolum <= w_bolum[ADIM_BIT];
            if (r_sayac == '0) r_state <= FIX;
            else               r_sayac <= r_sayac - CNT_W'(1);
          end
        end
        FIX: begin
          r_mesgul <= 1'b0;
          if (iptal_i) begin
            r_state <= IDLE;
          end else begin
            r_sonuc <= w_sonuc;
            r_bitti <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sonuc_o  = r_sonuc;
  assign bitti_o  = r_bitti;
  assign mesgul_o = r_mesgul;

endmodule
